lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store memory access controller between the execute stage and the data memory bus.
//  It issues word-aligned bus transactions with byte enables, splits misaligned accesses into two,
//  and merges split read data. It drives the word and byte offset consumed by the load extraction unit.
//  The busy output stalls the core while an access is outstanding.
// PARAMETERS
//  DW  32  data/address bus width in bits (fixed 32; bus is 4 byte lanes)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   reset, asynchronous, active-high
//  req_valid    in   1   execute stage presents a memory op
//  req_ready    out  1   controller can accept (IDLE only)
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 treated as word
//  req_addr     in   DW  byte address
//  req_wdata    in   DW  store data, LSB-aligned
//  mem_req      out  1   bus request, held until mem_gnt
//  mem_gnt      in   1   bus accepted request this cycle
//  mem_addr     out  DW  word address, [1:0]=00
//  mem_we       out  1   bus write
//  mem_be       out  4   byte lane enables
//  mem_wdata    out  DW  lane-positioned write data
//  mem_rvalid   in   1   read data valid / write ack (once per granted request)
//  mem_rdata    in   DW  read word
//  rsp_valid    out  1   one-cycle pulse: access complete
//  rsp_word     out  DW  load word for extraction; 0 for stores
//  rsp_off      out  2   byte offset for extraction (req_addr[1:0], or 00 after split merge)
//  busy         out  1   high from accept until the rsp_valid cycle inclusive
// BEHAVIOUR
//  Reset: state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_word, rsp_off, busy = 0.
//  req_ready = (state==IDLE) & ~rst.
//  FSM: IDLE -> REQ0 on req_valid&req_ready (latch we/size/addr/wdata, off=addr[1:0], n=1/2/4 bytes).
//   REQ0: mem_req=1; on mem_gnt -> WAIT0. WAIT0: on mem_rvalid latch r0 -> REQ1 if split else RESP.
//   REQ1/WAIT1: same, second word, latch r1 -> RESP. RESP: rsp_valid=1 for one cycle -> IDLE.
//  Split iff off+n > 4 (half @ off 3; word @ off 1..3). Non-split covers byte at any offset, half at 0..2.
//  Addresses: access0 = addr&~3; access1 = access0+4 mod 2^32 (0xFFFFFFFC wraps to 0x00000000).
//  Byte enables: non-split be = ((1<<n)-1)<<off; split be0 = (4'hF<<off)&4'hF,
//   be1 = (1<<(off+n-4))-1.
//  Write data: access0 = wdata<<(8*off); access1 = wdata>>(8*(4-off)). Lanes with be=0 are don't-care.
//  Non-split load: rsp_word=r0, rsp_off=off.
//  Split load: rsp_word = (r0>>(8*off)) | (r1<<(8*(4-off))), rsp_off=00.
//  Stores: rsp_word=0, rsp_off=00.
//  mem_addr/mem_we/mem_be/mem_wdata stable while mem_req=1 and mem_gnt=0; mem_req drops the cycle after gnt.
//  mem_gnt may be high in the first REQ cycle (zero wait). mem_rvalid is at least 1 cycle after gnt.
//  mem_rvalid outside WAIT0/WAIT1 and mem_gnt outside REQ0/REQ1 are ignored.
//  Latency, zero-wait bus: accept T0, mem_req T1 (gnt), rvalid T2, rsp_valid T3, req_ready T4.
//   Split: rsp_valid T5. Each extra wait cycle on gnt or rvalid adds 1.
//  Reset mid-access: immediate return to IDLE, mem_req=0, no rsp_valid; pending bus response discarded.
//  rsp_word/rsp_off hold their value until the next rsp_valid.
// TESTING
//  LW 0x100, rdata=0xDEADBEEF, zero wait -> mem_addr=0x100, be=1111, rsp_valid@T3, rsp_word=0xDEADBEEF, off=0.
//  SB 0x203 data=0x000000AB -> mem_addr=0x200, be=1000, mem_wdata[31:24]=0xAB, mem_we=1, rsp_word=0.
//  LW 0x101: words 0x100=0x44332211, 0x104=0x88776655 -> two accesses, be 1110 then 0001,
//   rsp_word=0x55443322, off=0, rsp_valid@T5.
//  SH 0xFFFFFFFF data=0xBEEF -> access0 0xFFFFFFFC be=1000 lane3=0xEF;
//   access1 0x00000000 be=0001 lane0=0xBE.
//  LB 0x102 with gnt delayed 3 cycles -> mem_req and addr stable for 4 cycles;
//   rsp_valid@T6, off=2; busy high T0..T6.
//  Assert rst during WAIT0 of a split load -> mem_req=0, req_ready=1 after release,
//   no rsp_valid; late mem_rvalid ignored.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store bus controller: issues word-aligned accesses with byte enables,
// splits accesses that cross a word boundary and merges the two read words.
module lsu_mem_ctrl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [DW-1:0] mem_addr,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_word,
    output logic [1:0]    rsp_off,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;

    state_e        state_q, state_d;
    logic          we_q, split_q;
    logic [1:0]    off_q;
    logic [3:0]    be1_q;
    logic [DW-1:0] wdata1_q, r0_q;
    logic [DW-1:0] mem_addr_q, mem_wdata_q, rsp_word_q;
    logic [3:0]    mem_be_q;
    logic          mem_we_q;
    logic [1:0]    rsp_off_q;

    logic          accept, split_in;
    logic [2:0]    n_bytes;
    logic [4:0]    mask5;
    logic [7:0]    be_full;
    logic [5:0]    sh_in, sh_q;
    logic [DW-1:0] wdata0, wdata1, merged;

    // Byte enables for both words come from one 8-lane mask: low nibble is
    // the first access, high nibble whatever spills into the next word.
    always_comb begin
        case (req_size)
            2'b00:   n_bytes = 3'd1;
            2'b01:   n_bytes = 3'd2;
            default: n_bytes = 3'd4;
        endcase
        mask5    = (5'd1 << n_bytes) - 5'd1;
        be_full  = {3'b000, mask5} << req_addr[1:0];
        split_in = ({1'b0, req_addr[1:0]} + n_bytes) > 3'd4;
        sh_in    = {1'b0, req_addr[1:0], 3'b000};
        wdata0   = req_wdata << sh_in;
        wdata1   = req_wdata >> (6'd32 - sh_in);
        sh_q     = {1'b0, off_q, 3'b000};
        merged   = (r0_q >> sh_q) | (mem_rdata << (6'd32 - sh_q));
    end

    assign req_ready = (state_q == IDLE) & ~rst;
    assign accept    = req_valid & req_ready;
    assign mem_req   = (state_q == REQ0) | (state_q == REQ1);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE) | accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept)     state_d = REQ0;
            REQ0:  if (mem_gnt)    state_d = WAIT0;
            WAIT0: if (mem_rvalid) state_d = split_q ? REQ1 : RESP;
            REQ1:  if (mem_gnt)    state_d = WAIT1;
            WAIT1: if (mem_rvalid) state_d = RESP;
            RESP:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            off_q       <= 2'b00;
            be1_q       <= 4'h0;
            wdata1_q    <= '0;
            r0_q        <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= '0;
            rsp_word_q  <= '0;
            rsp_off_q   <= 2'b00;
        end else begin
            if (accept) begin
                we_q        <= req_we;
                split_q     <= split_in;
                off_q       <= req_addr[1:0];
                be1_q       <= be_full[7:4];
                wdata1_q    <= wdata1;
                mem_addr_q  <= {req_addr[DW-1:2], 2'b00};
                mem_we_q    <= req_we;
                mem_be_q    <= be_full[3:0];
                mem_wdata_q <= wdata0;
            end
            if (state_q == WAIT0 && mem_rvalid) begin
                r0_q <= mem_rdata;
                if (split_q) begin
                    // Second word wraps naturally at the top of the address space
                    mem_addr_q  <= mem_addr_q + 32'd4;
                    mem_be_q    <= be1_q;
                    mem_wdata_q <= wdata1_q;
                end else begin
                    rsp_word_q <= we_q ? '0 : mem_rdata;
                    rsp_off_q  <= we_q ? 2'b00 : off_q;
                end
            end
            if (state_q == WAIT1 && mem_rvalid) begin
                rsp_word_q <= we_q ? '0 : merged;
                rsp_off_q  <= 2'b00;
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_word  = rsp_word_q;
    assign rsp_off   = rsp_off_q;

endmodule
